// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the data-memory stage and the ext_dm
// load-extension block.
//   ld_op_e   : load operation encodings (3 bits)
//   st_op_e   : store operation encodings (2 bits)
//   DEPTH_LOG2_DEF : default log2 of RAM depth in 32-bit words
//   is_load / ld_misaligned : load decode helpers
package mem_pkg;

  localparam int DEPTH_LOG2_DEF = 10;

  typedef enum logic [2:0] {
    LD_LW   = 3'b000,
    LD_LBU  = 3'b001,
    LD_LB   = 3'b010,
    LD_LHU  = 3'b011,
    LD_LH   = 3'b100,
    LD_NONE = 3'b111
  } ld_op_e;

  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_SB   = 2'b01,
    ST_SH   = 2'b10,
    ST_SW   = 2'b11
  } st_op_e;

  // Only the five defined load codes count as loads; reserved codes
  // (101, 110) behave like "no load".
  function automatic logic is_load(input logic [2:0] op);
    logic r;
    r = 1'b0;
    case (op)
      LD_LW, LD_LBU, LD_LB, LD_LHU, LD_LH: r = 1'b1;
      default:                             r = 1'b0;
    endcase
    return r;
  endfunction

  // Byte loads can never fault; halfword loads need addr[0]=0; word
  // loads need addr[1:0]=0.
  function automatic logic ld_misaligned(input logic [2:0] op,
                                         input logic [1:0] lo);
    logic r;
    r = 1'b0;
    case (op)
      LD_LW:         r = (lo != 2'b00);
      LD_LHU, LD_LH: r = lo[0];
      default:       r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dm_be_gen.sv
// dm_be_gen: combinational store-lane generator.
// Ports:
//   st_op_i    : store op (ST_NONE/SB/SH/SW)
//   addr_lo_i  : byte offset addr[1:0]
//   wdata_i    : right-aligned store data
//   be_o       : per-byte write enable (all zero when misaligned or no store)
//   wdata_o    : store data replicated across the byte lanes
//   misalign_o : store is misaligned and must not write
module dm_be_gen
  import mem_pkg::*;
(
  input  logic [1:0]  st_op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);

  // Replicating the narrow data into every lane lets the RAM write path
  // stay a plain per-byte mux: the enable alone picks the target lane.
  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = wdata_i;
    misalign_o = 1'b0;
    case (st_op_i)
      ST_SB: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      ST_SH: begin
        wdata_o = {2{wdata_i[15:0]}};
        if (addr_lo_i[0]) begin
          misalign_o = 1'b1;
        end else begin
          be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        end
      end
      ST_SW: begin
        if (addr_lo_i != 2'b00) begin
          misalign_o = 1'b1;
        end else begin
          be_o = 4'b1111;
        end
      end
      default: begin
        be_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/dm_mem.sv
// dm_mem: data-memory pipeline stage.
// Word-organised RAM with byte-enable stores (sb/sh/sw) and registered
// word reads feeding ext_dm. Misaligned accesses raise adel_q/ades_q and
// capture the faulting address.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   en, stall, flush  : stage valid / hold / kill
//   addr, wdata       : byte address, right-aligned store data
//   st_op, ld_op      : store / load operation
//   dout, a_q, op_q   : registered raw word, byte offset, load op (to ext_dm)
//   valid_q           : registered outputs carry a live load
//   adel_q, ades_q    : load / store address-error flags
//   badaddr_q         : faulting address
module dm_mem
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  st_op,
  input  logic [2:0]  ld_op,
  output logic [31:0] dout,
  output logic [1:0]  a_q,
  output logic [2:0]  op_q,
  output logic        valid_q,
  output logic        adel_q,
  output logic        ades_q,
  output logic [31:0] badaddr_q
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           ram_q [DEPTH];
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0]           rd_word;

  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic        st_mis;

  logic live;
  logic is_st;
  logic is_ld;
  logic ld_mis;
  logic wr_en;

  logic [31:0] dout_q, dout_d;
  logic [1:0]  a_d;
  logic [2:0]  op_d;
  logic        valid_d;
  logic        adel_d;
  logic        ades_d;
  logic [31:0] badaddr_d;

  dm_be_gen u_be_gen (
    .st_op_i    (st_op),
    .addr_lo_i  (addr[1:0]),
    .wdata_i    (wdata),
    .be_o       (be),
    .wdata_o    (wdata_rep),
    .misalign_o (st_mis)
  );

  // Upper address bits are dropped so accesses wrap modulo the RAM size.
  // A store alongside a load is illegal; the store wins, so is_ld is
  // masked by is_st.
  always_comb begin
    word_idx = addr[DEPTH_LOG2+1:2];
    rd_word  = ram_q[word_idx];
    live     = en & ~flush & ~stall;
    is_st    = (st_op != ST_NONE);
    is_ld    = ~is_st & is_load(ld_op);
    ld_mis   = is_ld & ld_misaligned(ld_op, addr[1:0]);
    wr_en    = live & is_st & ~st_mis;
  end

  // Output next-state. Everything holds by default (covers stall, even
  // with flush). An unstalled bubble (en low or flushed) only drops the
  // valid and error flags. A live instruction rewrites dout with the
  // addressed word (pre-write contents for stores) unless it faults.
  always_comb begin
    dout_d    = dout_q;
    a_d       = a_q;
    op_d      = op_q;
    valid_d   = valid_q;
    adel_d    = adel_q;
    ades_d    = ades_q;
    badaddr_d = badaddr_q;
    if (!stall) begin
      valid_d = 1'b0;
      adel_d  = 1'b0;
      ades_d  = 1'b0;
      if (live) begin
        if (is_st) begin
          if (st_mis) begin
            ades_d    = 1'b1;
            badaddr_d = addr;
          end else begin
            dout_d = rd_word;
          end
        end else if (is_ld) begin
          if (ld_mis) begin
            adel_d    = 1'b1;
            badaddr_d = addr;
          end else begin
            dout_d  = rd_word;
            a_d     = addr[1:0];
            op_d    = ld_op;
            valid_d = 1'b1;
          end
        end else begin
          dout_d = rd_word;
        end
      end
    end
  end

  // Stage output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q    <= 32'h0;
      a_q       <= 2'b00;
      op_q      <= LD_NONE;
      valid_q   <= 1'b0;
      adel_q    <= 1'b0;
      ades_q    <= 1'b0;
      badaddr_q <= 32'h0;
    end else begin
      dout_q    <= dout_d;
      a_q       <= a_d;
      op_q      <= op_d;
      valid_q   <= valid_d;
      adel_q    <= adel_d;
      ades_q    <= ades_d;
      badaddr_q <= badaddr_d;
    end
  end

  // RAM contents are never reset, but an edge seen while reset is held
  // must not write, hence the rst_n qualifier on the enable.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          ram_q[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_dm_mem.sv
// tb_dm_mem: scoreboard bench for dm_mem. Directed instructions push the
// expected load result or address-error event into a queue; a monitor
// pops and compares whenever the stage presents a load or a fault.
module tb_dm_mem;
  import mem_pkg::*;

  localparam int K_LOAD = 0;
  localparam int K_ADEL = 1;
  localparam int K_ADES = 2;

  typedef struct {
    int          kind;
    string       name;
    logic [31:0] dout;
    logic [1:0]  a;
    logic [2:0]  op;
    logic [31:0] bad;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        stall;
  logic        flush;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  st_op;
  logic [2:0]  ld_op;
  logic [31:0] dout;
  logic [1:0]  a_q;
  logic [2:0]  op_q;
  logic        valid_q;
  logic        adel_q;
  logic        ades_q;
  logic [31:0] badaddr_q;

  exp_t sbq[$];
  int   vectors;
  int   miscompares;

  dm_mem #(.DEPTH_LOG2(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .stall     (stall),
    .flush     (flush),
    .addr      (addr),
    .wdata     (wdata),
    .st_op     (st_op),
    .ld_op     (ld_op),
    .dout      (dout),
    .a_q       (a_q),
    .op_q      (op_q),
    .valid_q   (valid_q),
    .adel_q    (adel_q),
    .ades_q    (ades_q),
    .badaddr_q (badaddr_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] got,
                             input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Inputs change on the falling edge; the rising edge then samples them.
  task automatic applyStimulus(input logic e, input logic s, input logic f,
                               input logic [31:0] a, input logic [31:0] w,
                               input logic [1:0] st, input logic [2:0] ld);
    @(negedge clk);
    en = e; stall = s; flush = f; addr = a; wdata = w; st_op = st; ld_op = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic doStore(input logic [31:0] a, input logic [31:0] w,
                         input logic [1:0] st);
    applyStimulus(1'b1, 1'b0, 1'b0, a, w, st, LD_NONE);
  endtask

  task automatic doLoad(input string name, input logic [31:0] a,
                        input logic [2:0] ld, input logic [31:0] expWord);
    exp_t e;
    e.kind = K_LOAD; e.name = name; e.dout = expWord;
    e.a = a[1:0]; e.op = ld; e.bad = 32'h0;
    sbq.push_back(e);
    applyStimulus(1'b1, 1'b0, 1'b0, a, 32'h0, ST_NONE, ld);
  endtask

  task automatic doFault(input string name, input int kind,
                         input logic [31:0] a, input logic [31:0] w,
                         input logic [1:0] st, input logic [2:0] ld);
    exp_t e;
    e.kind = kind; e.name = name; e.dout = 32'h0;
    e.a = 2'b00; e.op = 3'b000; e.bad = a;
    sbq.push_back(e);
    applyStimulus(1'b1, 1'b0, 1'b0, a, w, st, ld);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ST_NONE, LD_NONE);
  endtask

  // Monitor: only edges that actually updated the stage (out of reset,
  // not stalled) can present a new event.
  always @(posedge clk) begin
    bit   upd;
    exp_t e;
    upd = (rst_n === 1'b1) && (stall === 1'b0);
    #1;
    if (upd && (valid_q === 1'b1 || adel_q === 1'b1 || ades_q === 1'b1)) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_event: got valid=%b adel=%b ades=%b expected no event",
                 valid_q, adel_q, ades_q);
      end else begin
        e = sbq.pop_front();
        if (e.kind == K_LOAD) begin
          checkOutput(e.name, {24'h0, valid_q, adel_q, ades_q, dout, a_q, op_q},
                      {24'h0, 1'b1, 1'b0, 1'b0, e.dout, e.a, e.op});
        end else if (e.kind == K_ADEL) begin
          checkOutput(e.name, {29'h0, valid_q, adel_q, ades_q, badaddr_q},
                      {29'h0, 1'b0, 1'b1, 1'b0, e.bad});
        end else begin
          checkOutput(e.name, {29'h0, valid_q, adel_q, ades_q, badaddr_q},
                      {29'h0, 1'b0, 1'b0, 1'b1, e.bad});
        end
      end
    end
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0; en = 1'b0; stall = 1'b0; flush = 1'b0;
    addr = 32'h0; wdata = 32'h0; st_op = ST_NONE; ld_op = LD_NONE;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_dout",    {32'h0, dout},                     64'h0);
    checkOutput("reset_a_op",    {59'h0, a_q, op_q},                64'h7);
    checkOutput("reset_flags",   {61'h0, valid_q, adel_q, ades_q},  64'h0);
    checkOutput("reset_badaddr", {32'h0, badaddr_q},                64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store / load, then byte and halfword merges over it.
    doStore(32'h10, 32'h11223344, ST_SW);
    doLoad("lw_0x10", 32'h10, LD_LW, 32'h11223344);
    doStore(32'h12, 32'h123456AA, ST_SB);
    doStore(32'h10, 32'hFFFFBEEF, ST_SH);
    doLoad("lw_merged", 32'h10, LD_LW, 32'h11AABEEF);
    doLoad("lbu_0x13", 32'h13, LD_LBU, 32'h11AABEEF);
    doLoad("lb_0x12",  32'h12, LD_LB,  32'h11AABEEF);

    // Address wrap modulo 4 KiB.
    doStore(32'h1000, 32'hCAFEF00D, ST_SW);
    doLoad("lw_wrap_0x0",    32'h0000, LD_LW, 32'hCAFEF00D);
    doLoad("lw_wrap_0x2000", 32'h2000, LD_LW, 32'hCAFEF00D);

    // Misaligned load and store; RAM at 0x20 must survive the bad sw.
    doStore(32'h20, 32'h55667788, ST_SW);
    doFault("adel_lh_0x21", K_ADEL, 32'h21, 32'h0, ST_NONE, LD_LH);
    doFault("ades_sw_0x22", K_ADES, 32'h22, 32'hDEADBEEF, ST_SW, LD_NONE);
    doLoad("lw_0x20_intact", 32'h20, LD_LW, 32'h55667788);
    doLoad("lhu_0x22",       32'h22, LD_LHU, 32'h55667788);

    // Stalled store then flushed: no write, outputs hold while stalled.
    doStore(32'h30, 32'h01010101, ST_SW);
    doLoad("lw_0x20_b", 32'h20, LD_LW, 32'h55667788);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h30, 32'hDEADDEAD, ST_SW, LD_NONE);
      checkOutput("stall_hold", {31'h0, valid_q, dout}, {31'h0, 1'b1, 32'h55667788});
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h30, 32'hDEADDEAD, ST_SW, LD_NONE);
    checkOutput("flush_out", {29'h0, valid_q, adel_q, ades_q, dout},
                {29'h0, 3'b000, 32'h55667788});
    doLoad("lw_after_flush", 32'h30, LD_LW, 32'h01010101);

    // Stalled store that is released performs exactly once.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h30, 32'h0BADF00D, ST_SW, LD_NONE);
    end
    doStore(32'h30, 32'h0BADF00D, ST_SW);
    doLoad("lw_after_stall", 32'h30, LD_LW, 32'h0BADF00D);

    // Reset asserted mid-store: outputs clear at once, store suppressed.
    doStore(32'h40, 32'h12121212, ST_SW);
    doLoad("lw_0x40_pre", 32'h40, LD_LW, 32'h12121212);
    @(negedge clk);
    en = 1'b1; stall = 1'b0; flush = 1'b0; addr = 32'h40;
    wdata = 32'h77777777; st_op = ST_SW; ld_op = LD_NONE;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_dout",  {32'h0, dout},                    64'h0);
    checkOutput("rst_mid_op",    {59'h0, a_q, op_q},               64'h7);
    checkOutput("rst_mid_flags", {61'h0, valid_q, adel_q, ades_q}, 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0; st_op = ST_NONE;
    doLoad("lw_0x40_post", 32'h40, LD_LW, 32'h12121212);

    idle();
    idle();
    checkOutput("scoreboard_drained", {32'h0, 32'(sbq.size())}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dm_mem.md
# dm_mem

Data-memory stage of the pipeline CPU. Holds the word-organised data RAM, executes sb/sh/sw with byte-enable merging, and performs word reads registered on the clock edge. Its registered outputs (raw word, byte offset, load op) feed the `ext_dm` load-extension block directly. It also detects misaligned accesses and raises address-error flags toward the exception logic.

## Interface
- `DEPTH_LOG2`, 10, log2 of RAM depth in 32-bit words; 1024 words = 4 KiB.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset; asynchronous, active-low.
- `en` input 1: MEM-stage instruction valid.
- `stall` input 1: hold the stage; no write, no output update.
- `flush` input 1: kill the MEM-stage instruction this cycle.
- `addr` input 32: byte address from the ALU.
- `wdata` input 32: store data, right-aligned (rt).
- `st_op` input 2: store op. 00 = none, 01 = sb, 10 = sh, 11 = sw.
- `ld_op` input 3: load op. 000 = lw, 001 = lbu, 010 = lb, 011 = lhu, 100 = lh, 111 = no load.
- `dout` output 32: registered raw RAM word; goes to ext_dm `Din`.
- `a_q` output 2: registered `addr[1:0]`; goes to ext_dm `A`.
- `op_q` output 3: registered `ld_op`; goes to ext_dm `op`.
- `valid_q` output 1: registered outputs carry a live load.
- `adel_q` output 1: load address-error flag.
- `ades_q` output 1: store address-error flag.
- `badaddr_q` output 32: faulting address, captured when either error flag sets.

## Operation
- Word index is `addr[DEPTH_LOG2+1:2]`. Upper address bits are ignored, so accesses wrap modulo RAM size.
- An instruction is live when `en & ~flush & ~stall`.
- Alignment faults:
  - sh with `addr[0]=1` is misaligned.
  - sw with `addr[1:0]!=0` is misaligned.
  - lh/lhu with `addr[0]=1` is misaligned.
  - lw with `addr[1:0]!=0` is misaligned.
  - sb, lb and lbu are never misaligned.
- Store, live and aligned: write the RAM at the edge with byte enables.
  - sb: `be = 1 << addr[1:0]`; `wdata[7:0]` is replicated to all byte lanes.
  - sh: `be = addr[1] ? 1100 : 0011`; `wdata[15:0]` is replicated to both halves.
  - sw: `be = 1111`.
  - Bytes not enabled keep their old value.
- Misaligned store: no write; `ades_q` is set to 1 and `badaddr_q` is set to `addr`.
- Load, live and aligned: at the edge, load `dout`, `a_q`, `op_q` and set `valid_q=1`.
- Misaligned load: set `valid_q=0`, `adel_q=1` and `badaddr_q=addr`.
- Live cycle with no load (`ld_op=111`): `valid_q=0`. `dout` still updates with the addressed word, for simplicity.
- A live instruction that raises no fault clears both `adel_q` and `ades_q`.
- Not-live cycles:
  - `flush` without `stall`: `valid_q=0`, both error flags 0, `dout`/`a_q`/`op_q` hold.
  - `stall`: all registers hold, including under `flush`. No RAM write.
- `st_op!=00` together with `ld_op!=111` is illegal. Store takes precedence and `valid_q=0`.
- RAM contents are not reset.
- Output reset values: `dout=0`, `a_q=0`, `op_q=3'b111`, `valid_q=0`, `adel_q=0`, `ades_q=0`, `badaddr_q=0`.

## Timing
- Load latency is 1 cycle: address presented in cycle N, data valid on `dout` after edge N. ext_dm output is combinational from there.
- A store at edge N is visible to a load whose edge is N+1 or later. There is no same-edge read/write overlap because one instruction occupies the stage.
- Error flags are registered: they appear after the edge of the faulting access and last one cycle unless `stall` holds them.
- Reset mid-operation: `rst_n` low forces outputs to reset values immediately. Any edge while `rst_n` is low performs no RAM write. The first live cycle after deassertion behaves normally.
- `stall` during a pending access means that access is not performed until the cycle in which `stall` is low.

## Structure
- Package `mem_pkg` holds:
  - `ld_op` encodings: `LD_LW`, `LD_LBU`, `LD_LB`, `LD_LHU`, `LD_LH`, `LD_NONE`.
  - `st_op` encodings: `ST_NONE`, `ST_SB`, `ST_SH`, `ST_SW`.
  - The `DEPTH_LOG2` default.
- `ext_dm` imports the same load encodings.
- Sub-module `dm_be_gen` is purely combinational. It maps `st_op`, `addr[1:0]` and `wdata` to the 4-bit byte enable, the lane-replicated write data, and the misalign flag.
- RAM is an inferred array with a per-byte write-enable loop.

## Test plan
- sw 0x11223344 to 0x10, then lw at 0x10: `dout=0x11223344`, `a_q=00`, `op_q=000`, `valid_q=1`, one cycle after the load.
- Over that word, sb 0xAA at 0x12, then sh 0xBEEF at 0x10, then lw 0x10: `dout=0x11AABEEF`.
- sw to 0x1003 (wrap) then lw 0x0003→ aligned equivalent: sw at 0x1000, then lw at 0x0000, gives the same word.
- lh at 0x21: `adel_q=1`, `badaddr_q=0x21`, `valid_q=0`. sw at 0x22: `ades_q=1` and the RAM word at 0x20 is unchanged.
- `stall` high for 3 cycles with sw pending: no write until `stall` drops, and outputs hold. `flush` with sw: no write, `valid_q=0`.
- Assert `rst_n` low mid-stream during a sw: outputs read reset values at once, `op_q=111`, and a subsequent lw of that address shows the store did not occur.
